// File: rtl/ex_ma_stage_if.sv
// ex_ma_stage_if: EX->MA stage boundary bundle.
//   master modport: the EX side (drives the *In signals, observes the *Out signals).
//   slave  modport: the EX->MA pipeline register itself.
//   Inputs : stallIn, flushIn, validIn, resultIn, lessIn, zeroIn, storeDataIn, rdIn,
//            regWriteIn, memReadIn, memWriteIn, branchTypeIn, branchTargetIn
//   Outputs: validOut, resultOut, lessOut, zeroOut, storeDataOut, rdOut, regWriteOut,
//            memReadOut, memWriteOut, branchTakenOut, branchTargetOut, fwdValidOut,
//            flushCountOut
interface ex_ma_stage_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
);
    logic              stallIn;
    logic              flushIn;
    logic              validIn;
    logic [DATA_W-1:0] resultIn;
    logic              lessIn;
    logic              zeroIn;
    logic [DATA_W-1:0] storeDataIn;
    logic [REG_AW-1:0] rdIn;
    logic              regWriteIn;
    logic              memReadIn;
    logic              memWriteIn;
    logic [1:0]        branchTypeIn;
    logic [DATA_W-1:0] branchTargetIn;

    logic              validOut;
    logic [DATA_W-1:0] resultOut;
    logic              lessOut;
    logic              zeroOut;
    logic [DATA_W-1:0] storeDataOut;
    logic [REG_AW-1:0] rdOut;
    logic              regWriteOut;
    logic              memReadOut;
    logic              memWriteOut;
    logic              branchTakenOut;
    logic [DATA_W-1:0] branchTargetOut;
    logic              fwdValidOut;
    logic [CNT_W-1:0]  flushCountOut;

    modport master (
        output stallIn, flushIn, validIn, resultIn, lessIn, zeroIn, storeDataIn, rdIn,
               regWriteIn, memReadIn, memWriteIn, branchTypeIn, branchTargetIn,
        input  validOut, resultOut, lessOut, zeroOut, storeDataOut, rdOut, regWriteOut,
               memReadOut, memWriteOut, branchTakenOut, branchTargetOut, fwdValidOut,
               flushCountOut
    );

    modport slave (
        input  stallIn, flushIn, validIn, resultIn, lessIn, zeroIn, storeDataIn, rdIn,
               regWriteIn, memReadIn, memWriteIn, branchTypeIn, branchTargetIn,
        output validOut, resultOut, lessOut, zeroOut, storeDataOut, rdOut, regWriteOut,
               memReadOut, memWriteOut, branchTakenOut, branchTargetOut, fwdValidOut,
               flushCountOut
    );
endinterface

// File: rtl/ex_ma_stage.sv
// ex_ma_stage: EX->MA pipeline register.
//   Latches ALU result/flags and EX control for the memory-access stage, resolves
//   conditional branches from the ALU flags into a one-cycle redirect pulse, exposes
//   a forwarding tap back to EX and counts flush cycles (saturating).
// Ports:
//   clkIn  - clock, rising edge
//   rstNIn - asynchronous active-low reset, clears every register
//   bus    - ex_ma_stage_if.slave, all stage inputs and outputs
//
// Flow control: validIn qualifies the EX instruction; there is no ready signal.
// stallIn is the back-pressure: while it is high the stage holds its contents and
// the EX instruction is not taken. flushIn overrides both and inserts a bubble.
// validOut qualifies everything on the MA side.
module ex_ma_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input logic           clkIn,
    input logic           rstNIn,
    ex_ma_stage_if.slave  bus
);
    logic              valid_q,     valid_d;
    logic [DATA_W-1:0] result_q,    result_d;
    logic              less_q,      less_d;
    logic              zero_q,      zero_d;
    logic [DATA_W-1:0] store_q,     store_d;
    logic [REG_AW-1:0] rd_q,        rd_d;
    logic              reg_write_q, reg_write_d;
    logic              mem_read_q,  mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic              taken_q,     taken_d;
    logic [DATA_W-1:0] target_q,    target_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

    logic branch_taken;

    // Branch resolution on the incoming ALU flags.
    always_comb begin
        branch_taken = 1'b0;
        case (bus.branchTypeIn)
            2'b01:   branch_taken = bus.zeroIn;   // beq
            2'b10:   branch_taken = ~bus.zeroIn;  // bne
            2'b11:   branch_taken = bus.lessIn;   // blt
            default: branch_taken = 1'b0;
        endcase
        branch_taken = branch_taken & bus.validIn;
    end

    always_comb begin
        // Default: hold. The redirect pulse is cleared on every edge that is not a capture.
        valid_d     = valid_q;
        result_d    = result_q;
        less_d      = less_q;
        zero_d      = zero_q;
        store_d     = store_q;
        rd_d        = rd_q;
        reg_write_d = reg_write_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        taken_d     = 1'b0;
        target_d    = target_q;

        if (bus.flushIn) begin
            valid_d     = 1'b0;
            result_d    = '0;
            less_d      = 1'b0;
            zero_d      = 1'b0;
            store_d     = '0;
            rd_d        = '0;
            reg_write_d = 1'b0;
            mem_read_d  = 1'b0;
            mem_write_d = 1'b0;
            target_d    = '0;
        end else if (!bus.stallIn) begin
            valid_d     = bus.validIn;
            result_d    = bus.resultIn;
            less_d      = bus.lessIn;
            zero_d      = bus.zeroIn;
            store_d     = bus.storeDataIn;
            rd_d        = bus.rdIn;
            // x0 is never written, so it is never a forwarding source either.
            reg_write_d = bus.regWriteIn & bus.validIn & (bus.rdIn != '0);
            mem_read_d  = bus.memReadIn & bus.validIn;
            mem_write_d = bus.memWriteIn & bus.validIn;
            taken_d     = branch_taken;
            target_d    = bus.branchTargetIn;
        end

        // Counts flush edges even while stalled; sticks at all-ones.
        flush_cnt_d = flush_cnt_q;
        if (bus.flushIn && (flush_cnt_q != {CNT_W{1'b1}})) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clkIn or negedge rstNIn) begin
        if (!rstNIn) begin
            valid_q     <= 1'b0;
            result_q    <= '0;
            less_q      <= 1'b0;
            zero_q      <= 1'b0;
            store_q     <= '0;
            rd_q        <= '0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            taken_q     <= 1'b0;
            target_q    <= '0;
            flush_cnt_q <= '0;
        end else begin
            valid_q     <= valid_d;
            result_q    <= result_d;
            less_q      <= less_d;
            zero_q      <= zero_d;
            store_q     <= store_d;
            rd_q        <= rd_d;
            reg_write_q <= reg_write_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            taken_q     <= taken_d;
            target_q    <= target_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign bus.validOut        = valid_q;
    assign bus.resultOut       = result_q;
    assign bus.lessOut         = less_q;
    assign bus.zeroOut         = zero_q;
    assign bus.storeDataOut    = store_q;
    assign bus.rdOut           = rd_q;
    assign bus.regWriteOut     = reg_write_q;
    assign bus.memReadOut      = mem_read_q;
    assign bus.memWriteOut     = mem_write_q;
    assign bus.branchTakenOut  = taken_q;
    assign bus.branchTargetOut = target_q;
    // Load data only exists after MA, so loads are not forwardable from here.
    assign bus.fwdValidOut     = valid_q & reg_write_q & ~mem_read_q;
    assign bus.flushCountOut   = flush_cnt_q;
endmodule
